// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin, burst-locked arbiter that lets two masters share the 8-bit dbus.
// Define DBUS_ARB_WATCHDOG_EN to build the stall watchdog (idle counter, lockout, timeout pulse).
module dbus_arbiter #(
  parameter int TIMEOUT_W = 12
) (
  input  logic       sysclk,
  input  logic       reset,

  input  logic       m0_req,
  output logic       m0_gnt,
  input  logic [7:0] m0_reg,
  input  logic       m0_w,
  input  logic       m0_r,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,

  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic [7:0] m1_reg,
  input  logic       m1_w,
  input  logic       m1_r,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,

  output logic [7:0] dbus_reg,
  output logic       dbus_w,
  output logic       dbus_r,
  output logic [7:0] dbus_data_out,
  input  logic [7:0] dbus_data_in,

  output logic       owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT0   = 2'd1,
    ST_GRANT1   = 2'd2,
    ST_HANDOVER = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [1:0] elig;
  logic       expire;

`ifdef DBUS_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]           lock_q, lock_d;
  logic                 timeout_q, timeout_d;
  logic                 own_strobe;

  // A locked-out master stays ineligible until it has dropped its request once.
  assign elig       = {m1_req & ~lock_q[1], m0_req & ~lock_q[0]};
  assign expire     = ((state_q == ST_GRANT0) || (state_q == ST_GRANT1)) && (&wd_cnt_q);
  assign own_strobe = (state_q == ST_GRANT1) ? (m1_w | m1_r) : (m0_w | m0_r);

  always_comb begin
    wd_cnt_d  = '0;
    lock_d    = lock_q;
    timeout_d = expire;

    if ((state_q == ST_GRANT0 || state_q == ST_GRANT1) && (state_d == state_q)) begin
      if (own_strobe)
        wd_cnt_d = '0;
      else if (&wd_cnt_q)
        wd_cnt_d = wd_cnt_q;
      else
        wd_cnt_d = wd_cnt_q + 1'b1;
    end

    if (!m0_req) lock_d[0] = 1'b0;
    if (!m1_req) lock_d[1] = 1'b0;
    // Expiry outranks a request drop at the same edge.
    if (expire && state_q == ST_GRANT0) lock_d[0] = 1'b1;
    if (expire && state_q == ST_GRANT1) lock_d[1] = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      lock_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign elig    = {m1_req, m0_req};
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      ST_IDLE: begin
        if (elig == 2'b11) begin
          state_d = prio_q ? ST_GRANT1 : ST_GRANT0;
          prio_d  = ~prio_q;
        end else if (elig[0]) begin
          state_d = ST_GRANT0;
          prio_d  = 1'b1;
        end else if (elig[1]) begin
          state_d = ST_GRANT1;
          prio_d  = 1'b0;
        end
      end
      ST_GRANT0:   if (expire || !m0_req) state_d = ST_HANDOVER;
      ST_GRANT1:   if (expire || !m1_req) state_d = ST_HANDOVER;
      ST_HANDOVER: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments; reset is synchronous, checked first.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign m0_gnt = (state_q == ST_GRANT0);
  assign m1_gnt = (state_q == ST_GRANT1);
  assign busy   = m0_gnt | m1_gnt;
  assign owner  = m1_gnt;

  always_comb begin
    dbus_reg      = 8'h00;
    dbus_w        = 1'b0;
    dbus_r        = 1'b0;
    dbus_data_out = 8'h00;
    if (m0_gnt) begin
      dbus_reg      = m0_reg;
      dbus_w        = m0_w;
      dbus_r        = m0_r;
      dbus_data_out = m0_w ? m0_wdata : 8'h00;
    end else if (m1_gnt) begin
      dbus_reg      = m1_reg;
      dbus_w        = m1_w;
      dbus_r        = m1_r;
      dbus_data_out = m1_w ? m1_wdata : 8'h00;
    end
  end

  assign m0_rdata = (m0_gnt && m0_r) ? dbus_data_in : 8'h00;
  assign m1_rdata = (m1_gnt && m1_r) ? dbus_data_in : 8'h00;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized and directed bench for dbus_arbiter against a cycle-level reference model.
// Honours DBUS_ARB_WATCHDOG_EN the same way the design does.
module tb_dbus_arbiter;

  localparam int TW       = 4;
  localparam int IDLE_MAX = (1 << TW) - 1;
`ifdef DBUS_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset;
  logic       m0_req, m0_w, m0_r, m1_req, m1_w, m1_r;
  logic [7:0] m0_reg, m0_wdata, m1_reg, m1_wdata, dbus_data_in;
  logic       m0_gnt, m1_gnt, dbus_w, dbus_r, owner, busy, timeout;
  logic [7:0] m0_rdata, m1_rdata, dbus_reg, dbus_data_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, whether the mandatory gap is pending,
  // whose turn it is on a tie, lockouts and the run of strobe-less owned cycles.
  int       mo_owner;
  bit       mo_gap;
  int       mo_rr;
  bit [1:0] mo_lock;
  int       mo_idle;
  bit       mo_pulse;

  always #5 sysclk = ~sysclk;

  dbus_arbiter #(.TIMEOUT_W(TW)) dut (
    .sysclk(sysclk), .reset(reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_reg(m0_reg), .m0_w(m0_w), .m0_r(m0_r),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_reg(m1_reg), .m1_w(m1_w), .m1_r(m1_r),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .dbus_reg(dbus_reg), .dbus_w(dbus_w), .dbus_r(dbus_r),
    .dbus_data_out(dbus_data_out), .dbus_data_in(dbus_data_in),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [1:0] req, stb, lock_set, elig;
    int       o, pick;
    req      = {m1_req, m0_req};
    stb      = {m1_w | m1_r, m0_w | m0_r};
    lock_set = 2'b00;
    if (reset) begin
      mo_owner = -1; mo_gap = 0; mo_rr = 0; mo_lock = 0; mo_idle = 0; mo_pulse = 0;
      return;
    end
    mo_pulse = 0;
    if (mo_owner >= 0) begin
      o = mo_owner;
      if (WD && mo_idle == IDLE_MAX) begin
        mo_owner = -1; mo_gap = 1; mo_idle = 0; mo_pulse = 1; lock_set[o] = 1'b1;
      end else if (!req[o]) begin
        mo_owner = -1; mo_gap = 1; mo_idle = 0;
      end else if (stb[o]) begin
        mo_idle = 0;
      end else if (mo_idle < IDLE_MAX) begin
        mo_idle++;
      end
    end else if (mo_gap) begin
      mo_gap = 0;
    end else begin
      elig = WD ? (req & ~mo_lock) : req;
      pick = -1;
      if (elig == 2'b11) pick = mo_rr;
      else if (elig[0]) pick = 0;
      else if (elig[1]) pick = 1;
      if (pick >= 0) begin
        mo_owner = pick; mo_rr = 1 - pick; mo_idle = 0;
      end
    end
    if (WD)
      for (int i = 0; i < 2; i++)
        if (lock_set[i]) mo_lock[i] = 1'b1;
        else if (!req[i]) mo_lock[i] = 1'b0;
  endtask

  task automatic sample();
    logic [7:0] e_reg, e_dout, e_rd0, e_rd1;
    logic       e_w, e_r;
    @(negedge sysclk);
    e_reg = 8'h00; e_w = 1'b0; e_r = 1'b0;
    if (mo_owner == 0) begin e_reg = m0_reg; e_w = m0_w; e_r = m0_r; end
    if (mo_owner == 1) begin e_reg = m1_reg; e_w = m1_w; e_r = m1_r; end
    e_dout = 8'h00;
    if (mo_owner == 0 && m0_w) e_dout = m0_wdata;
    if (mo_owner == 1 && m1_w) e_dout = m1_wdata;
    e_rd0 = (mo_owner == 0 && m0_r) ? dbus_data_in : 8'h00;
    e_rd1 = (mo_owner == 1 && m1_r) ? dbus_data_in : 8'h00;
    check("m0_gnt",   32'(m0_gnt),        32'(mo_owner == 0));
    check("m1_gnt",   32'(m1_gnt),        32'(mo_owner == 1));
    check("busy",     32'(busy),          32'(mo_owner >= 0));
    check("owner",    32'(owner),         32'(mo_owner == 1));
    check("timeout",  32'(timeout),       32'(mo_pulse));
    check("dbus_reg", 32'(dbus_reg),      32'(e_reg));
    check("dbus_w",   32'(dbus_w),        32'(e_w));
    check("dbus_r",   32'(dbus_r),        32'(e_r));
    check("dbus_do",  32'(dbus_data_out), 32'(e_dout));
    check("m0_rdata", 32'(m0_rdata),      32'(e_rd0));
    check("m1_rdata", 32'(m1_rdata),      32'(e_rd1));
  endtask

  task automatic advance();
    @(posedge sysclk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic quiet_inputs();
    m0_req = 0; m0_w = 0; m0_r = 0; m0_reg = 0; m0_wdata = 0;
    m1_req = 0; m1_w = 0; m1_r = 0; m1_reg = 0; m1_wdata = 0;
    dbus_data_in = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  int g0, g1, tos;

  initial begin
    mo_owner = -1; mo_gap = 0; mo_rr = 0; mo_lock = 0; mo_idle = 0; mo_pulse = 0;
    reset = 1;
    quiet_inputs();
    #1;

    // Reset state
    do_reset();
    sample();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt0", 32'(m0_gnt), 32'd0);
    advance();

    // Single master write; master 1 strobes are ignored
    m0_req = 1;
    cycle();
    m0_w = 1; m0_reg = 8'h12; m0_wdata = 8'hA5;
    m1_w = 1; m1_reg = 8'h77; m1_wdata = 8'h33;
    sample();
    check("sm_gnt0", 32'(m0_gnt), 32'd1);
    check("sm_reg",  32'(dbus_reg), 32'h12);
    check("sm_dout", 32'(dbus_data_out), 32'hA5);
    check("sm_w",    32'(dbus_w), 32'd1);
    advance();
    quiet_inputs();
    repeat (3) cycle();

    // Simultaneous requests after reset, release timing, read path, round robin
    do_reset();
    m0_req = 1; m1_req = 1;
    cycle();
    sample();
    check("both_gnt0", 32'(m0_gnt), 32'd1);
    advance();
    m0_req = 0;
    cycle();
    sample();
    check("ho_busy", 32'(busy), 32'd0);
    advance();
    sample();
    check("idle_busy", 32'(busy), 32'd0);
    advance();
    m1_r = 1; m1_reg = 8'h30; dbus_data_in = 8'h5C; m0_r = 1; m0_reg = 8'h44;
    sample();
    check("rd_gnt1",   32'(m1_gnt), 32'd1);
    check("rd_dbus_r", 32'(dbus_r), 32'd1);
    check("rd_reg",    32'(dbus_reg), 32'h30);
    check("rd_m1",     32'(m1_rdata), 32'h5C);
    check("rd_m0",     32'(m0_rdata), 32'h00);
    advance();
    m1_r = 0; m0_r = 0; m1_req = 0; m0_req = 1;
    cycle();
    m1_req = 1;
    cycle();
    cycle();
    sample();
    check("rr_gnt0", 32'(m0_gnt), 32'd1);
    advance();

    // Stalled owner: revoked with lockout when the watchdog exists, held otherwise
    do_reset();
    m0_req = 1;
    cycle();
    g0 = 0; g1 = 0; tos = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 18) m1_req = 1;
      sample();
      g0 += int'(m0_gnt); g1 += int'(m1_gnt); tos += int'(timeout);
      advance();
    end
    check("wd_gnt0_cycles", 32'(g0),  WD ? 32'd16 : 32'd30);
    check("wd_timeouts",    32'(tos), WD ? 32'd1  : 32'd0);
    check("wd_gnt1_cycles", 32'(g1),  WD ? 32'd11 : 32'd0);

    // A strobe part way through restarts the idle count
    do_reset();
    m0_req = 1;
    cycle();
    g0 = 0;
    for (int i = 0; i < 30; i++) begin
      m0_w = (i == 14);
      sample();
      g0 += int'(m0_gnt);
      advance();
    end
    check("wd_restart_gnt0", 32'(g0), 32'd30);

    // Reset mid-write while master 1 owns the bus
    do_reset();
    m1_req = 1;
    cycle();
    m1_w = 1; m1_reg = 8'h55; m1_wdata = 8'h66; m0_req = 1;
    reset = 1;
    sample();
    check("mid_w", 32'(dbus_w), 32'd1);
    advance();
    reset = 0;
    sample();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_w0",   32'(dbus_w), 32'd0);
    check("mid_reg",  32'(dbus_reg), 32'd0);
    advance();
    sample();
    check("mid_gnt0", 32'(m0_gnt), 32'd1);
    advance();

    // Randomized traffic with alternating busy and stalled epochs
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit stall;
      stall = ((c / 400) % 2) == 1;
      if ($urandom_range(0, 7) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      m0_w = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      m0_r = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
      m1_w = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      m1_r = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
      m0_reg = 8'($urandom); m0_wdata = 8'($urandom);
      m1_reg = 8'($urandom); m1_wdata = 8'($urandom);
      dbus_data_in = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the 8-bit register bus (dbus) that feeds the TDC configuration and readout registers. It lets the UART command FSM and a second bus master (the I2C slave front-end) share one dbus. Grants are round-robin and burst-locked: the owner keeps the bus until it drops its request. An optional watchdog revokes a grant from a master that stalls.

## Interface
- `TIMEOUT_W`, default 12: watchdog counter width. Revoke occurs after 2^TIMEOUT_W−1 idle owned cycles.
- `sysclk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `m0_req` in 1: master 0 (UART FSM) bus request, level, held for the whole burst.
- `m0_gnt` out 1: master 0 owns the bus.
- `m0_reg` in 8: master 0 register address.
- `m0_w` in 1: master 0 write strobe.
- `m0_r` in 1: master 0 read strobe.
- `m0_wdata` in 8: master 0 write data.
- `m0_rdata` out 8: read data to master 0.
- `m1_req`, `m1_gnt`, `m1_reg`, `m1_w`, `m1_r`, `m1_wdata`, `m1_rdata`: identical set for master 1 (I2C).
- `dbus_reg` out 8: bus register address.
- `dbus_w` out 1: bus write strobe.
- `dbus_r` out 1: bus read strobe.
- `dbus_data_out` out 8: bus write data.
- `dbus_data_in` in 8: bus read data, combinational from the register file.
- `owner` out 1: index of the current owner; valid only while `busy`=1.
- `busy` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse when a grant is revoked.

## Operation
- States: IDLE, GRANT0, GRANT1, HANDOVER. State, `prio` pointer and lockout flags are registered.
- IDLE:
  - Only `m0_req` eligible -> GRANT0. Only `m1_req` eligible -> GRANT1.
  - Both eligible -> grant the master selected by `prio`. Neither -> stay in IDLE.
- GRANTx:
  - `mx_req`=0 -> HANDOVER.
  - Watchdog expiry -> HANDOVER, pulse `timeout` and set `lockx`.
  - Otherwise stay in GRANTx.
- HANDOVER: the bus is idle for one cycle, then the FSM returns to IDLE unconditionally.
- Round robin: on entering GRANTx, `prio` is set to the other master. Reset value of `prio` is 0.
- Eligibility: a master is eligible when `mx_req`=1 and `lockx`=0. `lockx` clears in any cycle where `mx_req`=0, so a revoked master must drop its request before it can be granted again.
- Bus mux:
  - While GRANTx, `dbus_reg`, `dbus_w`, `dbus_r` and `dbus_data_out` follow master x combinationally.
  - In IDLE and HANDOVER these outputs are forced to 0.
  - `dbus_data_out` is 0 whenever `dbus_w`=0.
- Read data: `mx_rdata` = `dbus_data_in` when `mx_gnt`=1 and `mx_r`=1, else 0.
- Strobes from a non-granted master are ignored and never reach the bus.
- `mx_gnt` is decoded from the registered state: `m0_gnt` = (state==GRANT0), `m1_gnt` = (state==GRANT1). `busy` is high in GRANT0 or GRANT1.

## Timing
- Reset values:
  - State IDLE, `prio`=0, `lock0`=`lock1`=0, watchdog counter = 0.
  - All outputs 0: gnts, dbus signals, rdata, `owner`, `busy`, `timeout`.
- Reset mid-burst: the bus drops to 0 on the next cycle with no HANDOVER. Masters must re-request.
- Grant latency: `mx_req` sampled high at edge N gives `mx_gnt`=1 after edge N. The master may strobe in that same cycle.
- Release: `mx_req` low at edge N gives HANDOVER after edge N and IDLE after edge N+1. The earliest next grant is after edge N+2.
- Req dropped and re-raised within one cycle: the master still passes through HANDOVER and IDLE. There is no back-to-back grant.
- Watchdog:
  - Counts cycles in GRANTx where `mx_w`=0 and `mx_r`=0.
  - Clears on any strobe, in any non-GRANT state, and on reset.
  - Saturates at 2^TIMEOUT_W−1 ("all ones"); no wrap.
  - When the counter is all-ones at the edge, the state moves to HANDOVER and `timeout`=1 for exactly that HANDOVER cycle.
- Request and expiry at the same edge: expiry wins and `lockx` is set.

## Configuration
- `DBUS_ARB_WATCHDOG_EN` defined:
  - The watchdog counter, lockout flags and `timeout` output logic are built.
  - Lockout is set only by watchdog expiry.
- `DBUS_ARB_WATCHDOG_EN` not defined:
  - No counter and no lockout; eligibility is `mx_req` alone.
  - `timeout` is tied to 0.
  - A grant is held until the owner releases `mx_req`.

## Test plan
- Single master: reset, then `m0_req`=1. Expect `m0_gnt`=1 one cycle later. A write of `m0_reg`=0x12, `m0_wdata`=0xA5 appears on `dbus_reg`=0x12, `dbus_data_out`=0xA5, `dbus_w`=1 in the same cycle. `m1_*` strobes are ignored.
- Simultaneous requests after reset: M0 is granted first. M0 releases; HANDOVER then IDLE, then M1 is granted at release+2. After M1 releases, with both requesting again, M0 is granted (round robin).
- Read path: M1 owns the bus, `m1_r`=1, `m1_reg`=0x30, `dbus_data_in`=0x5C. Expect `dbus_r`=1, `m1_rdata`=0x5C, `m0_rdata`=0.
- Watchdog with macro defined and TIMEOUT_W=4: M0 is granted with no strobes.
  - Expect revoke after 15 idle cycles and a `timeout` pulse of exactly 1 cycle.
  - M0 holding `m0_req` is not re-granted; M1 is granted if it requests.
  - A single strobe at idle cycle 14 restarts the count.
- Without the macro: the same stimulus holds the grant indefinitely and `timeout` stays 0.
- Reset asserted mid-write while GRANT1: the next cycle has all outputs 0 and state IDLE. With both still requesting after reset release, M0 is granted.
